trigger_meas: RTL

Measurement and checking receiver for the start/trigger pair produced by the periodic trigger generator. The block synchronises both inputs into `aclk` and waits for a start rising edge. After that it measures the high and low width of every trigger period in `aclk` cycles. It then compares each period against expected widths and counts complete periods. It sits at the receiving end of the trigger link, in loopback tests or on a downstream board, and its outputs feed a register slave or an ILA.

---
 rtl/trigger_meas.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/trigger_meas.sv
// rtl/trigger_meas.sv - start/trigger period measurement and checking receiver
// Synchronises start/trigger, measures high/low widths per period, compares to expected.

module trigger_meas #(
  parameter int B     = 16,
  parameter int NSYNC = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         en,
  input  logic         start,
  input  logic         trigger,
  input  logic [B-1:0] exp_width0,
  input  logic [B-1:0] exp_width1,
  output logic [B-1:0] width0,
  output logic [B-1:0] width1,
  output logic         valid,
  output logic         match,
  output logic [31:0]  ntrig,
  output logic         err,
  output logic         ovf,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam logic [B-1:0] CNT_MAX = {B{1'b1}};
  localparam logic [B-1:0] CNT_ONE = {{(B-1){1'b0}}, 1'b1};

  logic [NSYNC-1:0] start_sync_q;
  logic [NSYNC-1:0] trig_sync_q;
  logic             start_dly_q;
  logic             trig_dly_q;

  state_t           state_q, state_d;
  logic [B-1:0]     cnt_q, cnt_d;
  logic [B-1:0]     pend_q, pend_d;
  logic [B-1:0]     width0_q, width0_d;
  logic [B-1:0]     width1_q, width1_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic [31:0]      ntrig_q, ntrig_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic             start_s, trig_s;
  logic             start_rise, trig_rise, trig_fall;
  logic             restart;
  logic             cnt_sat;
  logic [B-1:0]     cnt_inc;
  logic             period_ok;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      start_sync_q <= '0;
      trig_sync_q  <= '0;
      start_dly_q  <= 1'b0;
      trig_dly_q   <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[NSYNC-2:0], start};
      trig_sync_q  <= {trig_sync_q[NSYNC-2:0], trigger};
      start_dly_q  <= start_sync_q[NSYNC-1];
      trig_dly_q   <= trig_sync_q[NSYNC-1];
    end
  end

  assign start_s    = start_sync_q[NSYNC-1];
  assign trig_s     = trig_sync_q[NSYNC-1];
  assign start_rise = start_s & ~start_dly_q;
  assign trig_rise  = trig_s & ~trig_dly_q;
  assign trig_fall  = ~trig_s & trig_dly_q;

  // A start rise outranks any trigger edge landing in the same cycle.
  assign restart   = en & start_rise;
  assign cnt_sat   = (cnt_q == CNT_MAX);
  assign cnt_inc   = cnt_sat ? cnt_q : cnt_q + CNT_ONE;
  assign period_ok = (cnt_q == exp_width0) && (pend_q == exp_width1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (restart) begin
      state_d = WAIT_EDGE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = IDLE;
        WAIT_EDGE: if (trig_rise) state_d = MEAS_HIGH;
        MEAS_HIGH: if (trig_fall) state_d = MEAS_LOW;
        MEAS_LOW:  if (trig_rise) state_d = MEAS_HIGH;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    width0_d = width0_q;
    width1_d = width1_q;
    valid_d  = 1'b0;
    match_d  = match_q;
    ntrig_d  = ntrig_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    if (en) begin
      if (restart) begin
        cnt_d   = '0;
        pend_d  = '0;
        ntrig_d = '0;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        unique case (state_q)
          WAIT_EDGE: begin
            if (trig_rise) cnt_d = CNT_ONE;
          end
          MEAS_HIGH: begin
            if (trig_fall) begin
              pend_d = cnt_q;
              cnt_d  = CNT_ONE;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_sat) ovf_d = 1'b1;
            end
          end
          MEAS_LOW: begin
            if (trig_rise) begin
              width0_d = cnt_q;
              width1_d = pend_q;
              valid_d  = 1'b1;
              match_d  = period_ok;
              ntrig_d  = ntrig_q + 32'd1;
              if (!period_ok) err_d = 1'b1;
              cnt_d    = CNT_ONE;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_sat) ovf_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q    <= '0;
      pend_q   <= '0;
      width0_q <= '0;
      width1_q <= '0;
      valid_q  <= 1'b0;
      match_q  <= 1'b0;
      ntrig_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      width0_q <= width0_d;
      width1_q <= width1_d;
      valid_q  <= valid_d;
      match_q  <= match_d;
      ntrig_q  <= ntrig_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    busy   = (state_q != IDLE);
    width0 = width0_q;
    width1 = width1_q;
    valid  = valid_q;
    match  = match_q;
    ntrig  = ntrig_q;
    err    = err_q;
    ovf    = ovf_q;
  end

endmodule
